// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and writeback.
//
// Accepts one op at a time over in_valid/in_ready. Loads and stores issue a
// single data-bus request (dreq_*) and wait for dresp_ok. Load data is
// extracted from the bus word and sign- or zero-extended. Non-memory ops pass
// in_alu through with one cycle of latency. Results are presented on out_*
// under out_valid/out_ready. Back-to-back accept is allowed in the cycle the
// result is consumed.
//
// Parameters: XLEN (32 or 64), REG_W (destination register index width).
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready, in_alu, in_wdata, in_rd, in_reg_w, in_mem_r,
//   in_mem_w, in_size, in_unsigned           - execute-side op
//   dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data - bus request
//   dresp_ok, dresp_data                     - bus response
//   out_valid/out_ready, out_data, out_rd, out_reg_w, out_misalign
//                                            - writeback-side result
//
// Build option: MEM_STAGE_MISALIGN_TRAP_EN
//   defined   - misaligned accesses skip the bus and return the address with
//               out_misalign=1 and out_reg_w=0.
//   undefined - address bits below the access size are masked to zero and
//               out_misalign is tied low.
module mem_stage #(
  parameter int XLEN  = 64,
  parameter int REG_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_alu,
  input  logic [XLEN-1:0]     in_wdata,
  input  logic [REG_W-1:0]    in_rd,
  input  logic                in_reg_w,
  input  logic                in_mem_r,
  input  logic                in_mem_w,
  input  logic [1:0]          in_size,
  input  logic                in_unsigned,
  output logic                dreq_valid,
  output logic [XLEN-1:0]     dreq_addr,
  output logic [1:0]          dreq_size,
  output logic [XLEN/8-1:0]   dreq_strobe,
  output logic [XLEN-1:0]     dreq_data,
  input  logic                dresp_ok,
  input  logic [XLEN-1:0]     dresp_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_data,
  output logic [REG_W-1:0]    out_rd,
  output logic                out_reg_w,
  output logic                out_misalign
);

  localparam int SW   = XLEN / 8;
  localparam int OFFW = $clog2(SW);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
  state_t state;

  // Byte-enable pattern for an access of 2^sz bytes starting at lane 0.
  function automatic logic [SW-1:0] lane_mask(input logic [1:0] sz);
    logic [8:0] full;
    full = (9'd1 << (4'd1 << sz)) - 9'd1;
    return SW'(full);
  endfunction

  // Shift the addressed bytes down to lane 0 and extend to full width.
  // A full-width access is returned unchanged, so in_unsigned has no effect.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] raw,
                                               input logic [OFFW-1:0] off,
                                               input logic [1:0]      sz,
                                               input logic            uns);
    logic [XLEN-1:0] sh;
    sh = raw >> {off, 3'b000};
    case (sz)
      2'd0:    load_ext = uns ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]));
      2'd1:    load_ext = uns ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]));
      2'd2:    load_ext = uns ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]));
      default: load_ext = sh;
    endcase
  endfunction

  // ---- stage 0: accept and lane computation ----
  logic             accept;
  logic             is_mem;
  logic             trap;
  logic [1:0]       sz_eff;
  logic [OFFW-1:0]  off_raw;
  logic [OFFW-1:0]  off_low;
  logic [OFFW-1:0]  off_al;
  logic [XLEN-1:0]  addr_al;

  assign in_ready = (state == S_IDLE) || (state == S_DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mem   = in_mem_r || in_mem_w;

  always_comb begin
    // A 32-bit datapath has no double accesses; size 3 degrades to word.
    sz_eff  = (XLEN == 32 && in_size == 2'd3) ? 2'd2 : in_size;
    off_raw = in_alu[OFFW-1:0];
    off_low = OFFW'((4'd1 << sz_eff) - 4'd1);
    off_al  = off_raw & ~off_low;
    addr_al = {in_alu[XLEN-1:OFFW], off_al};
  end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign trap = is_mem && ((off_raw & off_low) != '0);
`else
  assign trap = 1'b0;
`endif

  // ---- stage 1: control FSM ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else if (accept) begin
      state <= (is_mem && !trap) ? S_REQ : S_DONE;
    end else if (state == S_REQ && dresp_ok) begin
      state <= S_DONE;
    end else if (state == S_DONE && out_ready) begin
      state <= S_IDLE;
    end
  end

  // ---- stage 1: request registers, stage 2: result registers ----
  logic [XLEN-1:0]  req_addr_p1;
  logic [1:0]       req_size_p1;
  logic [SW-1:0]    req_strobe_p1;
  logic [XLEN-1:0]  req_data_p1;
  logic             ld_p1;
  logic [1:0]       ld_size_p1;
  logic             ld_uns_p1;
  logic [XLEN-1:0]  res_data_p2;
  logic [REG_W-1:0] res_rd_p2;
  logic             res_reg_w_p2;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic             res_mis_p2;
`endif

  // Data registers carry no reset; outputs are gated by state instead.
  // The result register is preloaded with in_alu, which is already the
  // final answer for pass-through, store and trapped ops.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_addr_p1   <= addr_al;
      req_size_p1   <= in_size;
      req_strobe_p1 <= (in_mem_w && !in_mem_r) ? (lane_mask(sz_eff) << off_al) : '0;
      req_data_p1   <= in_wdata << {off_al, 3'b000};
      ld_p1         <= in_mem_r;
      ld_size_p1    <= sz_eff;
      ld_uns_p1     <= in_unsigned;
      res_data_p2   <= in_alu;
      res_rd_p2     <= in_rd;
      res_reg_w_p2  <= in_reg_w && !trap;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      res_mis_p2    <= trap;
`endif
    end else if (state == S_REQ && dresp_ok && ld_p1) begin
      res_data_p2 <= load_ext(dresp_data, req_addr_p1[OFFW-1:0], ld_size_p1, ld_uns_p1);
    end
  end

  // ---- outputs ----
  assign dreq_valid  = (state == S_REQ);
  assign dreq_addr   = dreq_valid ? req_addr_p1   : '0;
  assign dreq_size   = dreq_valid ? req_size_p1   : '0;
  assign dreq_strobe = dreq_valid ? req_strobe_p1 : '0;
  assign dreq_data   = dreq_valid ? req_data_p1   : '0;

  assign out_valid   = (state == S_DONE);
  assign out_data    = out_valid ? res_data_p2  : '0;
  assign out_rd      = out_valid ? res_rd_p2    : '0;
  assign out_reg_w   = out_valid && res_reg_w_p2;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign out_misalign = out_valid && res_mis_p2;
`else
  assign out_misalign = 1'b0;
`endif

endmodule
